pc_sequencer: RTL and testbench

- Fetch-side controller that drives the program counter register's next-PC input (pc_in) and write-enable (i_PCWrite).
- Chooses the next PC from: sequential PC+4, branch/jump redirects, the trap vector, or a hold.
- Handles the instruction-memory request/ready handshake and generates IF/ID and ID/EX flushes.
- Sits between the hazard unit, the EX-stage branch resolution and the PC register.

---
 rtl/pc_seq_pkg.sv | 20 ++
 rtl/pc_sequencer_if.sv | 33 +++
 rtl/pc_sequencer_wait_timer.sv | 27 ++
 rtl/pc_sequencer.sv | 158 +++++++++++++++
 tb/tb_pc_sequencer.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-side PC sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_TRAP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_EXT      = 2'b01,
        CAUSE_MISALIGN = 2'b10,
        CAUSE_TIMEOUT  = 2'b11
    } cause_e;

    localparam int unsigned PC_STEP = 32'd4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Hazard/branch/imem/PC-register signals seen by the PC sequencer.
interface pc_sequencer_if #(parameter int XLEN = 32);
    logic            i_stall;
    logic            i_br_taken;
    logic [XLEN-1:0] i_br_target;
    logic            i_jmp;
    logic [XLEN-1:0] i_jmp_target;
    logic            i_trap;
    logic            i_imem_ready;
    logic [XLEN-1:0] i_pc_cur;
    logic [XLEN-1:0] o_pc_next;
    logic            o_pc_write;
    logic            o_imem_req;
    logic            o_fetch_valid;
    logic            o_flush_ifid;
    logic            o_flush_idex;
    logic            o_trap_taken;
    logic [1:0]      o_cause;

    modport master (
        input  i_stall, i_br_taken, i_br_target, i_jmp, i_jmp_target,
               i_trap, i_imem_ready, i_pc_cur,
        output o_pc_next, o_pc_write, o_imem_req, o_fetch_valid,
               o_flush_ifid, o_flush_idex, o_trap_taken, o_cause
    );

    modport slave (
        output i_stall, i_br_taken, i_br_target, i_jmp, i_jmp_target,
               i_trap, i_imem_ready, i_pc_cur,
        input  o_pc_next, o_pc_write, o_imem_req, o_fetch_valid,
               o_flush_ifid, o_flush_idex, o_trap_taken, o_cause
    );
endinterface

// File: rtl/pc_sequencer_wait_timer.sv
// Counts imem wait cycles; expired flags the last permitted wait cycle.
module pc_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [7:0] count_r;

    // wait-cycle counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= 8'd0;
        end else if (clear) begin
            count_r <= 8'd0;
        end else if (enable) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = enable & (count_r == 8'(MAX_WAIT - 1));
endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side next-PC controller: boot, sequential fetch, imem wait, redirects and traps.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0040,
    parameter int              MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            reset,
    pc_sequencer_if.master  bus
);
    state_e          state_r, state_s;
    cause_e          cause_r, trap_cause_s;
    logic [XLEN-1:0] pend_target_r, redir_target_s, pc_inc_s;
    logic            pend_valid_r;
    logic            redir_any_s, misalign_s, redir_s, active_s, in_wait_s;
    logic            expired_s, timeout_s, trap_req_s, latch_s;
    logic            pc_write_s, fetch_valid_s, flush_s;
    logic [XLEN-1:0] pc_next_s;

    assign redir_any_s    = bus.i_br_taken | bus.i_jmp;
    assign redir_target_s = bus.i_br_taken ? bus.i_br_target : bus.i_jmp_target;
    assign misalign_s     = redir_any_s & (redir_target_s[1:0] != 2'b00);
    assign redir_s        = redir_any_s & ~misalign_s;
    assign in_wait_s      = (state_r == S_WAIT);
    assign active_s       = (state_r == S_FETCH) | in_wait_s;
    assign timeout_s      = expired_s & ~bus.i_imem_ready;
    assign trap_req_s     = active_s & (bus.i_trap | timeout_s | misalign_s);
    assign trap_cause_s   = bus.i_trap ? CAUSE_EXT : (timeout_s ? CAUSE_TIMEOUT : CAUSE_MISALIGN);
    assign pc_inc_s       = bus.i_pc_cur + XLEN'(PC_STEP);
    // A redirect seen while imem is still busy is parked until ready
    assign latch_s        = in_wait_s & ~trap_req_s & redir_s & ~bus.i_imem_ready;

    pc_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_s != S_WAIT),
        .enable  (in_wait_s),
        .expired (expired_s)
    );

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= S_BOOT;
        else       state_r <= state_s;
    end

    // next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_BOOT:  state_s = S_FETCH;
            S_FETCH: begin
                if (trap_req_s)                           state_s = S_TRAP;
                else if (redir_s | bus.i_stall | bus.i_imem_ready) state_s = S_FETCH;
                else                                      state_s = S_WAIT;
            end
            S_WAIT: begin
                if (trap_req_s)            state_s = S_TRAP;
                else if (bus.i_imem_ready) state_s = S_FETCH;
                else                       state_s = S_WAIT;
            end
            S_TRAP:  state_s = S_FETCH;
            default: state_s = S_BOOT;
        endcase
    end

    // PC-register drive, fetch valid and flushes
    always_comb begin
        pc_next_s     = bus.i_pc_cur;
        pc_write_s    = 1'b0;
        fetch_valid_s = 1'b0;
        flush_s       = 1'b0;
        case (state_r)
            S_BOOT: begin
                pc_next_s  = RESET_PC;
                pc_write_s = 1'b1;
            end
            S_FETCH: begin
                if (trap_req_s) begin
                    pc_write_s = 1'b0;
                end else if (redir_s) begin
                    pc_next_s  = redir_target_s;
                    pc_write_s = 1'b1;
                    flush_s    = 1'b1;
                end else if (bus.i_stall) begin
                    pc_write_s = 1'b0;
                end else if (bus.i_imem_ready) begin
                    pc_next_s     = pc_inc_s;
                    pc_write_s    = 1'b1;
                    fetch_valid_s = 1'b1;
                end else begin
                    pc_write_s = 1'b0;
                end
            end
            S_WAIT: begin
                if (trap_req_s) begin
                    pc_write_s = 1'b0;
                end else if (redir_s) begin
                    flush_s    = 1'b1;
                    pc_next_s  = bus.i_imem_ready ? redir_target_s : bus.i_pc_cur;
                    pc_write_s = bus.i_imem_ready;
                end else if (bus.i_imem_ready & pend_valid_r) begin
                    pc_next_s  = pend_target_r;
                    pc_write_s = 1'b1;
                end else if (bus.i_imem_ready & ~bus.i_stall) begin
                    pc_next_s     = pc_inc_s;
                    pc_write_s    = 1'b1;
                    fetch_valid_s = 1'b1;
                end else begin
                    pc_write_s = 1'b0;
                end
            end
            S_TRAP: begin
                pc_next_s  = TRAP_VEC;
                pc_write_s = 1'b1;
                flush_s    = 1'b1;
            end
            default: pc_write_s = 1'b0;
        endcase
    end

    // pending redirect captured during an imem wait
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid_r  <= 1'b0;
            pend_target_r <= '0;
        end else if (latch_s) begin
            pend_valid_r  <= 1'b1;
            pend_target_r <= redir_target_s;
        end else if (state_s != S_WAIT) begin
            pend_valid_r  <= 1'b0;
            pend_target_r <= pend_target_r;
        end else begin
            pend_valid_r  <= pend_valid_r;
            pend_target_r <= pend_target_r;
        end
    end

    // trap cause: set on trap entry, cleared by the next good fetch
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              cause_r <= CAUSE_NONE;
        else if (trap_req_s)    cause_r <= trap_cause_s;
        else if (fetch_valid_s) cause_r <= CAUSE_NONE;
        else                    cause_r <= cause_r;
    end

    assign bus.o_pc_next     = pc_next_s;
    assign bus.o_pc_write    = pc_write_s;
    assign bus.o_fetch_valid = fetch_valid_s;
    assign bus.o_flush_ifid  = flush_s;
    assign bus.o_flush_idex  = flush_s;
    assign bus.o_imem_req    = active_s;
    assign bus.o_trap_taken  = (state_r == S_TRAP);
    assign bus.o_cause       = cause_r;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer with a behavioural PC register.
module tb_pc_sequencer;
    typedef struct {
        string       tag;
        logic [39:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_reg = 32'h0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];

    pc_sequencer_if #(.XLEN(32)) bus ();

    pc_sequencer #(.MAX_WAIT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // program counter register fed by the sequencer
    always_ff @(posedge clk or posedge reset) begin
        if (reset)               pc_reg <= 32'h0;
        else if (bus.o_pc_write) pc_reg <= bus.o_pc_next;
        else                     pc_reg <= pc_reg;
    end
    assign bus.i_pc_cur = pc_reg;

    function automatic logic [39:0] mk(input logic [31:0] pc, input logic w, input logic v,
                                       input logic f, input logic t, input logic r,
                                       input logic [1:0] c);
        return {pc, w, v, f, f, t, r, c};
    endfunction

    task automatic push(input string tag, input logic [39:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic sample();
        exp_t        e;
        logic [39:0] obs;
        obs = {bus.o_pc_next, bus.o_pc_write, bus.o_fetch_valid, bus.o_flush_ifid,
               bus.o_flush_idex, bus.o_trap_taken, bus.o_imem_req, bus.o_cause};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cyc(input string tag, input logic [39:0] val);
        push(tag, val);
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic st, input logic br, input logic [31:0] bt,
                          input logic jp, input logic [31:0] jt, input logic tr,
                          input logic rdy);
        bus.i_stall      = st;
        bus.i_br_taken   = br;
        bus.i_br_target  = bt;
        bus.i_jmp        = jp;
        bus.i_jmp_target = jt;
        bus.i_trap       = tr;
        bus.i_imem_ready = rdy;
    endtask

    initial begin
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        #2 reset = 1'b1;
        push("reset_state", mk(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
        @(negedge clk);
        sample();
        @(posedge clk);
        #1 reset = 1'b0;
        // boot and sequential fetch
        cyc("boot",  mk(32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
        cyc("seq4",  mk(32'h4,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00));
        cyc("seq8",  mk(32'h8,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00));
        cyc("seq12", mk(32'hC,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00));
        cyc("seq16", mk(32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00));
        // two-cycle stall at 0x10
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc("stall1", mk(32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00));
        cyc("stall2", mk(32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00));
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc("resume", mk(32'h14, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00));
        // branch overrides stall
        set_in(1'b1, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc("br_stall", mk(32'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00));
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc("after_br", mk(32'h84, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00));
        // misaligned jump traps instead of loading 0x82
        set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'h82, 1'b0, 1'b1);
        cyc("misalign_hold", mk(32'h84, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00));
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc("misalign_trap", mk(32'h40, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10));
        cyc("trap_fetch",    mk(32'h44, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10));
        cyc("cause_clear",   mk(32'h48, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00));
        // imem timeout after three wait cycles
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc("miss",    mk(32'h48, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00));
        cyc("wait1",   mk(32'h48, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00));
        cyc("wait2",   mk(32'h48, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00));
        cyc("wait3",   mk(32'h48, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00));
        cyc("timeout", mk(32'h40, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11));
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc("to_fetch", mk(32'h44, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11));
        cyc("to_clear", mk(32'h48, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00));
        // redirect parked during wait, ready arrives on the last allowed cycle
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc("miss2", mk(32'h48, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00));
        set_in(1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc("wait_redir", mk(32'h48, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00));
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc("wait_pend", mk(32'h48, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00));
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc("pend_load", mk(32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00));
        cyc("pend_seq",  mk(32'h204, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00));
        // asynchronous reset in the middle of a wait with a redirect pending
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc("miss3", mk(32'h204, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00));
        set_in(1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0);
        push("wait_redir2", mk(32'h204, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00));
        @(negedge clk);
        sample();
        #2;
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        reset = 1'b1;
        push("async_reset", mk(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
        #1;
        sample();
        @(posedge clk);
        #1 reset = 1'b0;
        cyc("reboot", mk(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
        cyc("rb_miss", mk(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00));
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc("rb_ready", mk(32'h4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00));
        // PC+4 wraps to zero
        set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
        cyc("jmp_top", mk(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00));
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc("wrap", mk(32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00));
        // external trap
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        cyc("ext_hold", mk(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00));
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc("ext_trap", mk(32'h40, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
